row3_window_gather: RTL and testbench

//  Consumer stage of the 4-RAM/3-row line buffer. On each Start_Row it reads the three buffered rows

---
 rtl/row3_window_gather.sv | 228 ++++++++++++++++++++++
 tb/tb_row3_window_gather.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row3_window_gather.sv
// row3_window_gather
// Reads three buffered rows through the line buffer's read port and builds 3x3
// windows (stride 1, no padding). Each window is handed downstream over a
// valid/ready stream. M_Busy keeps the line buffer from rotating its row RAMs
// while this stage still needs them.
module row3_window_gather #(
    parameter int WIDTH_DATA         = 8,
    parameter int PICTURE_NUM        = 1,
    parameter int CHANNEL_IN_NUM     = 16,
    parameter int WIDTH_RAM_SIZE     = 10,
    parameter int WIDTH_FEATURE_SIZE = 12,
    parameter int WIDTH_CHANNEL_NUM  = 10,
    localparam int CH_W = WIDTH_DATA * PICTURE_NUM * CHANNEL_IN_NUM
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Start_Row,
    input  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding,
    input  logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG,
    output logic                          M_Busy,
    output logic [WIDTH_RAM_SIZE-1:0]     Rd_Addr,
    input  logic [3*CH_W-1:0]             Row_Data,
    output logic [9*CH_W-1:0]             W_Data,
    output logic [WIDTH_CHANNEL_NUM-1:0]  W_Group,
    output logic                          W_Last,
    output logic                          W_Valid,
    input  logic                          W_Ready
);

    localparam int CG_SHIFT = $clog2(CHANNEL_IN_NUM);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_DRAIN  = 3'd2,
        S_HOLD   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                          state_r, state_s;
    logic [1:0]                      cnt_r;
    logic                            busy_r;
    logic [WIDTH_FEATURE_SIZE-1:0]   w_r;
    logic [WIDTH_CHANNEL_NUM-1:0]    ct_r, ct_in_s;
    logic [WIDTH_FEATURE_SIZE-1:0]   oc_r;
    logic [WIDTH_CHANNEL_NUM-1:0]    g_r;
    logic [WIDTH_RAM_SIZE-1:0]       base_r;   // window index == oc*CT+g, first-column address
    logic [WIDTH_RAM_SIZE-1:0]       rd_addr_r;
    logic [1:0]                      vld_p_r;  // read-return pipeline, one bit per latency stage
    logic [1:0]                      kx_p0_r, kx_p1_r;
    logic [9*CH_W-1:0]               data_r;
    logic [WIDTH_CHANNEL_NUM-1:0]    w_group_r;
    logic                            w_last_r;
    logic                            w_valid_r;
    logic                            last_s;

    assign M_Busy  = busy_r;
    assign Rd_Addr = rd_addr_r;
    assign W_Data  = data_r;
    assign W_Group = w_group_r;
    assign W_Last  = w_last_r;
    assign W_Valid = w_valid_r;

    // Channel-group count from the channel register, with zero groups treated as one.
    always_comb begin
        ct_in_s = Channel_In_Num_REG >> CG_SHIFT;
        if (ct_in_s == '0) begin
            ct_in_s = WIDTH_CHANNEL_NUM'(1);
        end else begin
            ct_in_s = Channel_In_Num_REG >> CG_SHIFT;
        end
    end

    // Current window is the last of the row: oc == W-3 and g == CT-1.
    always_comb begin
        last_s = 1'b0;
        if ((({1'b0, oc_r} + (WIDTH_FEATURE_SIZE+1)'(3)) == {1'b0, w_r}) &&
            ((g_r + WIDTH_CHANNEL_NUM'(1)) == ct_r)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state logic of the row sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (Start_Row) begin
                    if (Row_Num_After_Padding >= WIDTH_FEATURE_SIZE'(3)) begin
                        state_s = S_ISSUE;
                    end else begin
                        state_s = S_FINISH;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cnt_r == 2'd2) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (cnt_r == 2'd1) begin
                    state_s = S_HOLD;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (W_Ready) begin
                    if (last_s) begin
                        state_s = S_FINISH;
                    end else begin
                        state_s = S_ISSUE;
                    end
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state, counters, address generation, gather register and stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= 2'd0;
            busy_r    <= 1'b0;
            w_r       <= '0;
            ct_r      <= WIDTH_CHANNEL_NUM'(1);
            oc_r      <= '0;
            g_r       <= '0;
            base_r    <= '0;
            rd_addr_r <= '0;
            vld_p_r   <= 2'b00;
            kx_p0_r   <= 2'd0;
            kx_p1_r   <= 2'd0;
            data_r    <= '0;
            w_group_r <= '0;
            w_last_r  <= 1'b0;
            w_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;

            // Phase counter restarts on every state change.
            if (state_s != state_r) begin
                cnt_r <= 2'd0;
            end else if ((state_r == S_ISSUE) || (state_r == S_DRAIN)) begin
                cnt_r <= cnt_r + 2'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            // Busy is released one cycle after the sequencer is back in IDLE.
            if (state_r == S_IDLE) begin
                busy_r <= (state_s != S_IDLE);
            end else begin
                busy_r <= 1'b1;
            end

            // Latch geometry on an accepted start; address starts at 0 only when reads follow.
            if ((state_r == S_IDLE) && Start_Row) begin
                w_r    <= Row_Num_After_Padding;
                ct_r   <= ct_in_s;
                oc_r   <= '0;
                g_r    <= '0;
                base_r <= '0;
                if (state_s == S_ISSUE) begin
                    rd_addr_r <= '0;
                end else begin
                    rd_addr_r <= rd_addr_r;
                end
            end else if ((state_r == S_ISSUE) && (cnt_r != 2'd2)) begin
                // Next column of the same channel group is CT words further on.
                rd_addr_r <= rd_addr_r + WIDTH_RAM_SIZE'(ct_r);
            end else if ((state_r == S_HOLD) && W_Ready && !last_s) begin
                // oc*CT+g steps by exactly one for both g+1 and (oc+1, g=0).
                base_r    <= base_r + WIDTH_RAM_SIZE'(1);
                rd_addr_r <= base_r + WIDTH_RAM_SIZE'(1);
                if ((g_r + WIDTH_CHANNEL_NUM'(1)) == ct_r) begin
                    g_r  <= '0;
                    oc_r <= oc_r + WIDTH_FEATURE_SIZE'(1);
                end else begin
                    g_r  <= g_r + WIDTH_CHANNEL_NUM'(1);
                    oc_r <= oc_r;
                end
            end else begin
                rd_addr_r <= rd_addr_r;
            end

            // Track which column each issued read belongs to across the two-cycle latency.
            vld_p_r <= {vld_p_r[0], (state_r == S_ISSUE)};
            kx_p0_r <= cnt_r;
            kx_p1_r <= kx_p0_r;
            if (vld_p_r[1]) begin
                for (int ky = 0; ky < 3; ky++) begin
                    data_r[(ky*3 + int'(kx_p1_r))*CH_W +: CH_W] <= Row_Data[ky*CH_W +: CH_W];
                end
            end else begin
                data_r <= data_r;
            end

            // Present the window once the third column has landed; drop it on acceptance.
            if ((state_r == S_DRAIN) && (cnt_r == 2'd1)) begin
                w_valid_r <= 1'b1;
                w_group_r <= g_r;
                w_last_r  <= last_s;
            end else if ((state_r == S_HOLD) && W_Ready) begin
                w_valid_r <= 1'b0;
                w_last_r  <= 1'b0;
            end else begin
                w_valid_r <= w_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_row3_window_gather.sv
// Bench for row3_window_gather: a line-buffer model with two-cycle read latency,
// a window-list model built directly from the row geometry, and one compare
// process that checks every accepted window and every stall cycle.
module tb_row3_window_gather;

    localparam int CH_W = 128;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 Start_Row;
    logic [11:0]          Row_Num_After_Padding;
    logic [9:0]           Channel_In_Num_REG;
    logic                 M_Busy;
    logic [9:0]           Rd_Addr;
    logic [3*CH_W-1:0]    Row_Data;
    logic [9*CH_W-1:0]    W_Data;
    logic [9:0]           W_Group;
    logic                 W_Last;
    logic                 W_Valid;
    logic                 W_Ready;

    int tests = 0;
    int fails = 0;

    row3_window_gather dut (
        .clk(clk), .rst(rst), .Start_Row(Start_Row),
        .Row_Num_After_Padding(Row_Num_After_Padding),
        .Channel_In_Num_REG(Channel_In_Num_REG),
        .M_Busy(M_Busy), .Rd_Addr(Rd_Addr), .Row_Data(Row_Data),
        .W_Data(W_Data), .W_Group(W_Group), .W_Last(W_Last),
        .W_Valid(W_Valid), .W_Ready(W_Ready)
    );

    always #5 clk = ~clk;

    // Pixel word of row ky at line-buffer address a; seed distinguishes rows of data.
    function automatic logic [CH_W-1:0] pix(input int seed, input int ky, input int a);
        logic [CH_W-1:0] v;
        for (int i = 0; i < CH_W/32; i++) begin
            v[i*32 +: 32] = 32'(seed*16777216 + ky*65536 + a*256 + i);
        end
        return v;
    endfunction

    // Line buffer model: data for an address appears two clocks later.
    int cur_seed = 0;
    int a1 = 0;
    int a2 = 0;
    always @(posedge clk) begin
        a1 <= int'(Rd_Addr);
        a2 <= a1;
    end
    assign Row_Data = {pix(cur_seed, 2, a2), pix(cur_seed, 1, a2), pix(cur_seed, 0, a2)};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected windows.
    logic [9*CH_W-1:0] exp_data_q[$];
    int                exp_grp_q[$];
    bit                exp_last_q[$];

    task automatic load_model(input int w, input int ct, input int seed);
        logic [9*CH_W-1:0] d;
        for (int oc = 0; oc <= w - 3; oc++) begin
            for (int g = 0; g < ct; g++) begin
                for (int ky = 0; ky < 3; ky++) begin
                    for (int kx = 0; kx < 3; kx++) begin
                        d[(ky*3+kx)*CH_W +: CH_W] = pix(seed, ky, (oc + kx)*ct + g);
                    end
                end
                exp_data_q.push_back(d);
                exp_grp_q.push_back(g);
                exp_last_q.push_back((oc == w - 3) && (g == ct - 1));
            end
        end
    endtask

    // Observation state written by the compare process.
    int addr_log[$];
    int grp_log[$];
    int exp_addr[$];
    int prev_addr = -1;
    int hs_count = 0;
    int stall_cycles = 0;
    logic [9*CH_W-1:0] first_win, last_win;
    bit stall_prev = 1'b0;
    logic [9*CH_W-1:0] held_data;
    logic [9:0] held_grp, held_addr;
    logic held_last;

    // Compare process: stall stability, accepted windows against the model, address trace.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("valid_held", 128'(W_Valid), 128'd1);
                chk("group_stable", 128'(W_Group), 128'(held_grp));
                chk("last_stable", 128'(W_Last), 128'(held_last));
                chk("addr_stable", 128'(Rd_Addr), 128'(held_addr));
                for (int t = 0; t < 9; t++) begin
                    chk($sformatf("data_stable_tap%0d", t), W_Data[t*CH_W +: CH_W], held_data[t*CH_W +: CH_W]);
                end
            end
            if (M_Busy && (int'(Rd_Addr) != prev_addr)) begin
                addr_log.push_back(int'(Rd_Addr));
                prev_addr = int'(Rd_Addr);
            end
            if (W_Valid && W_Ready) begin
                if (exp_data_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_window: got handshake group %0d expected none", W_Group);
                end else begin
                    logic [9*CH_W-1:0] ed;
                    ed = exp_data_q.pop_front();
                    for (int t = 0; t < 9; t++) begin
                        chk($sformatf("win%0d_tap%0d", hs_count, t), W_Data[t*CH_W +: CH_W], ed[t*CH_W +: CH_W]);
                    end
                    chk($sformatf("win%0d_group", hs_count), 128'(W_Group), 128'(exp_grp_q.pop_front()));
                    chk($sformatf("win%0d_last", hs_count), 128'(W_Last), 128'(exp_last_q.pop_front()));
                end
                if (hs_count == 0) first_win = W_Data;
                last_win = W_Data;
                grp_log.push_back(int'(W_Group));
                hs_count++;
            end
            if (W_Valid && !W_Ready) stall_cycles++;
            stall_prev = W_Valid && !W_Ready;
            held_data  = W_Data;
            held_grp   = W_Group;
            held_last  = W_Last;
            held_addr  = Rd_Addr;
        end
    end

    task automatic begin_test();
        addr_log.delete();
        grp_log.delete();
        prev_addr    = -1;
        hs_count     = 0;
        stall_cycles = 0;
    endtask

    task automatic start_row(input int w, input int ch, input int seed, input bit load);
        @(posedge clk); #1;
        if (load) begin
            cur_seed = seed;
            load_model(w, (ch >> 4) == 0 ? 1 : (ch >> 4), seed);
        end
        Row_Num_After_Padding = 12'(w);
        Channel_In_Num_REG    = 10'(ch);
        Start_Row             = 1'b1;
        @(posedge clk); #1;
        Start_Row             = 1'b0;
        Row_Num_After_Padding = 12'd7;
        Channel_In_Num_REG    = 10'd0;
    endtask

    task automatic wait_done(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!M_Busy && exp_data_q.size() == 0) done = 1'b1;
        end
        chk({nm, "_done_in_time"}, 128'(done), 128'd1);
    endtask

    task automatic wait_hs(input int n, input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            if (hs_count >= n) done = 1'b1;
        end
        chk({nm, "_hs_in_time"}, 128'(done), 128'd1);
    endtask

    task automatic chk_addrs(input string nm);
        chk({nm, "_addr_count"}, 128'(addr_log.size()), 128'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
            chk($sformatf("%s_addr%0d", nm, i), 128'(addr_log[i]), 128'(exp_addr[i]));
        end
    endtask

    initial begin
        rst = 1'b1;
        Start_Row = 1'b0;
        Row_Num_After_Padding = 12'd0;
        Channel_In_Num_REG = 10'd0;
        W_Ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 128'(M_Busy), 128'd0);
        chk("rst_addr", 128'(Rd_Addr), 128'd0);
        chk("rst_valid", 128'(W_Valid), 128'd0);
        chk("rst_last", 128'(W_Last), 128'd0);
        chk("rst_group", 128'(W_Group), 128'd0);
        chk("rst_data", 128'(|W_Data), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: W=5, CT=1, plus an ignored Start_Row while busy.
        begin_test();
        start_row(5, 16, 1, 1'b1);
        chk("t1_busy_after_start", 128'(M_Busy), 128'd1);
        repeat (4) @(posedge clk);
        #1;
        start_row(3, 16, 9, 1'b0);
        wait_hs(3, "t1");
        @(negedge clk); chk("t1_busy_finish", 128'(M_Busy), 128'd1);
        @(negedge clk); chk("t1_busy_idle", 128'(M_Busy), 128'd1);
        @(negedge clk); chk("t1_busy_low", 128'(M_Busy), 128'd0);
        repeat (20) @(negedge clk);
        chk("t1_windows", 128'(hs_count), 128'd3);
        chk("t1_pin_tap12", 128'(first_win[5*CH_W +: 32]), 128'h01010200);
        exp_addr = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        chk_addrs("t1");

        // T3: stall window 2 for 10 cycles.
        begin_test();
        start_row(5, 16, 2, 1'b1);
        wait_hs(1, "t3");
        #1 W_Ready = 1'b0;
        for (int i = 0; i < 50 && !W_Valid; i++) @(negedge clk);
        repeat (10) @(posedge clk);
        #1 W_Ready = 1'b1;
        wait_done("t3");
        chk("t3_windows", 128'(hs_count), 128'd3);
        chk("t3_stall_cycles", 128'(stall_cycles), 128'd10);
        exp_addr = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        chk_addrs("t3");

        // T4: W=2 produces no windows; busy for FINISH and the IDLE cycle only.
        begin_test();
        start_row(2, 16, 3, 1'b1);
        @(negedge clk); chk("t4_busy_c1", 128'(M_Busy), 128'd1); chk("t4_valid_c1", 128'(W_Valid), 128'd0);
        @(negedge clk); chk("t4_busy_c2", 128'(M_Busy), 128'd1); chk("t4_valid_c2", 128'(W_Valid), 128'd0);
        @(negedge clk); chk("t4_busy_c3", 128'(M_Busy), 128'd0);
        repeat (10) @(negedge clk);
        chk("t4_windows", 128'(hs_count), 128'd0);

        // T5: reset during DRAIN of window 2, then a W=3 row.
        begin_test();
        start_row(5, 16, 4, 1'b1);
        wait_hs(1, "t5");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_busy", 128'(M_Busy), 128'd0);
        chk("t5_rst_addr", 128'(Rd_Addr), 128'd0);
        chk("t5_rst_valid", 128'(W_Valid), 128'd0);
        chk("t5_rst_last", 128'(W_Last), 128'd0);
        chk("t5_rst_group", 128'(W_Group), 128'd0);
        chk("t5_rst_data", 128'(|W_Data), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_data_q.delete();
        exp_grp_q.delete();
        exp_last_q.delete();
        begin_test();
        start_row(3, 16, 5, 1'b1);
        wait_done("t5");
        chk("t5_windows", 128'(hs_count), 128'd1);
        exp_addr = '{0, 1, 2};
        chk_addrs("t5");

        // T6/T2: back-to-back row with new geometry W=4, CT=2.
        begin_test();
        start_row(4, 32, 6, 1'b1);
        wait_done("t2");
        chk("t2_windows", 128'(hs_count), 128'd4);
        exp_addr = '{0, 2, 4, 1, 3, 5, 2, 4, 6, 3, 5, 7};
        chk_addrs("t2");
        chk("t2_grp_count", 128'(grp_log.size()), 128'd4);
        for (int i = 0; i < 4 && i < grp_log.size(); i++) begin
            chk($sformatf("t2_grp%0d", i), 128'(grp_log[i]), 128'(i % 2));
        end
        chk("t2_pin_tap20", 128'(last_win[6*CH_W +: 32]), 128'h06020300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
